// File: rtl/ip_sequencer_pkg.sv
// Shared encodings for the instruction sequencer: control-flow class/sub-field
// values, field geometry, FSM states and the next-address control bundle.
package ip_sequencer_pkg;

  localparam logic [1:0] CLS_ALU  = 2'b00;
  localparam logic [1:0] CLS_JMP  = 2'b01;
  localparam logic [1:0] CLS_CALL = 2'b10;
  localparam logic [1:0] CLS_MISC = 2'b11;

  localparam logic [1:0] SUB_BZ   = 2'b00;
  localparam logic [1:0] SUB_RET  = 2'b01;
  localparam logic [1:0] SUB_EXEC = 2'b10;

  // Class occupies the top CLS_W bits of the word, sub-field the next SUB_W.
  localparam int CLS_W = 2;
  localparam int SUB_W = 2;

  typedef enum logic {
    ST_FETCH = 1'b0,
    ST_ISSUE = 1'b1
  } seq_state_t;

  typedef struct packed {
    logic imm_sel;
    logic reg_sel;
    logic tos_sel;
    logic skip;
    logic push;
    logic pop;
  } ip_ctl_t;

  localparam ip_ctl_t IP_CTL_NONE = '0;

endpackage

// File: rtl/ip_decode.sv
// Combinational control-flow decoder: instruction word to next-address selects
// and return-stack push/pop. Shared with the disassembler/trace monitor.
module ip_decode
  import ip_sequencer_pkg::*;
#(
  parameter int insn_width = 16
) (
  input  logic [insn_width-1:0] insn,
  output ip_ctl_t               ctl
);

  logic [CLS_W-1:0] cls;
  logic [SUB_W-1:0] sub;
  logic             unused_low;

  assign cls        = insn[insn_width-1 -: CLS_W];
  assign sub        = insn[insn_width-1-CLS_W -: SUB_W];
  assign unused_low = ^insn[insn_width-CLS_W-SUB_W-1:0];

  always_comb begin
    ctl = IP_CTL_NONE;
    case (cls)
      CLS_JMP: ctl.imm_sel = 1'b1;
      CLS_CALL: begin
        ctl.imm_sel = 1'b1;
        ctl.push    = 1'b1;
      end
      CLS_MISC: begin
        case (sub)
          SUB_BZ: begin
            ctl.skip    = 1'b1;
            ctl.imm_sel = 1'b1;
          end
          SUB_RET: begin
            ctl.reg_sel = 1'b1;
            ctl.pop     = 1'b1;
          end
          SUB_EXEC: begin
            ctl.reg_sel = 1'b1;
            ctl.tos_sel = 1'b1;
          end
          // Reserved sub-field falls through as a plain IP+1 instruction.
          default: ctl = IP_CTL_NONE;
        endcase
      end
      default: ctl = IP_CTL_NONE;
    endcase
  end

endmodule

// File: rtl/ip_sequencer.sv
// Instruction sequencer: owns IP, fetches one word per pass over req/ack,
// presents it to the datapath and commits the next-address result on accept.
module ip_sequencer
  import ip_sequencer_pkg::*;
#(
  parameter int                     iaddr_width  = 10,
  parameter int                     insn_width   = 16,
  parameter logic [iaddr_width-1:0] reset_vector = '0
) (
  input  logic                   clk,
  input  logic                   rst_n,
  output logic                   imem_req,
  output logic [iaddr_width-1:0] imem_addr,
  input  logic                   imem_ack,
  input  logic [insn_width-1:0]  imem_data,
  output logic [insn_width-1:0]  insn,
  output logic                   insn_valid,
  input  logic                   insn_ready,
  output logic [iaddr_width-1:0] ip,
  output logic [iaddr_width-1:0] ip_imm,
  output logic                   ip_imm_sel,
  output logic                   ip_reg_sel,
  output logic                   ip_tos_sel,
  output logic                   ip_skip,
  input  logic [iaddr_width-1:0] ip_inc,
  input  logic [iaddr_width-1:0] ip_result,
  output logic                   rpush,
  output logic [iaddr_width-1:0] rpush_data,
  output logic                   rpop
);

  seq_state_t             state, state_nxt;
  logic [iaddr_width-1:0] ip_q;
  logic [insn_width-1:0]  insn_q;
  ip_ctl_t                ctl;
  logic                   fetch_done;
  logic                   issue_done;

  ip_decode #(
    .insn_width(insn_width)
  ) u_decode (
    .insn(insn_q),
    .ctl (ctl)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) state <= ST_FETCH;
    else        state <= state_nxt;
  end

  // Every output is gated by rst_n so nothing leaks while reset is held,
  // including a return-stack push when reset lands on an accepted CALL.
  always_comb begin
    state_nxt  = state;
    imem_req   = 1'b0;
    insn_valid = 1'b0;
    ip_imm_sel = 1'b0;
    ip_reg_sel = 1'b0;
    ip_tos_sel = 1'b0;
    ip_skip    = 1'b0;
    rpush      = 1'b0;
    rpop       = 1'b0;
    fetch_done = 1'b0;
    issue_done = 1'b0;
    if (rst_n) begin
      case (state)
        ST_FETCH: begin
          imem_req = 1'b1;
          if (imem_ack) begin
            fetch_done = 1'b1;
            state_nxt  = ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          insn_valid = 1'b1;
          ip_imm_sel = ctl.imm_sel;
          ip_reg_sel = ctl.reg_sel;
          ip_tos_sel = ctl.tos_sel;
          ip_skip    = ctl.skip;
          if (insn_ready) begin
            issue_done = 1'b1;
            rpush      = ctl.push;
            rpop       = ctl.pop;
            state_nxt  = ST_FETCH;
          end
        end
        default: state_nxt = ST_FETCH;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ip_q   <= reset_vector;
      insn_q <= '0;
    end else begin
      if (fetch_done) insn_q <= imem_data;
      if (issue_done) ip_q   <= ip_result;
    end
  end

  assign imem_addr  = ip_q;
  assign ip         = ip_q;
  assign insn       = insn_q;
  assign ip_imm     = insn_q[iaddr_width-1:0];
  assign rpush_data = ip_inc;

endmodule

// File: doc/ip_sequencer.md
# ip_sequencer

Instruction sequencer for the stack CPU. It owns the IP register and fetches one instruction per pass from instruction memory over a req/ack handshake. It classifies each instruction's control-flow field and drives the select lines of the combinational IP next-address unit. It commits the unit's result back into IP once the datapath accepts the instruction, and issues return-stack push/pop for CALL/RET.

## Interface
Parameters:
- `iaddr_width`, 10: instruction address width.
- `insn_width`, 16: instruction word width; must be at least `iaddr_width + 4`.
- `reset_vector`, 0: IP value after reset.

Ports (one clock; reset is synchronous and active-low):
- `clk` in 1: clock, all state on rising edge.
- `rst_n` in 1: synchronous active-low reset.
- `imem_req` out 1: fetch request.
- `imem_addr` out iaddr_width: fetch address, equals IP.
- `imem_ack` in 1: fetch complete; `imem_data` valid this cycle.
- `imem_data` in insn_width: fetched word.
- `insn` out insn_width: held instruction to the datapath decoder.
- `insn_valid` out 1: `insn` is presented.
- `insn_ready` in 1: datapath consumes `insn` this cycle.
- `ip` out iaddr_width: current IP, fed to the next-address unit.
- `ip_imm` out iaddr_width: `insn[iaddr_width-1:0]`.
- `ip_imm_sel`, `ip_reg_sel`, `ip_tos_sel`, `ip_skip` out 1 each: next-address selects.
- `ip_inc` in iaddr_width: IP+1 from the next-address unit.
- `ip_result` in iaddr_width: next IP from the next-address unit.
- `rpush` out 1: push `rpush_data` onto the return stack.
- `rpush_data` out iaddr_width: return address, equals `ip_inc`.
- `rpop` out 1: pop the return stack.

## Operation
- Class field is `insn[insn_width-1:insn_width-2]`; sub-field is the next two bits.
  - 00 ALU: all selects 0, giving IP+1.
  - 01 JMP: `ip_imm_sel`=1.
  - 10 CALL: `ip_imm_sel`=1, plus `rpush` with `rpush_data`=`ip_inc`.
  - 11/00 BZ: `ip_skip`=1 and `ip_imm_sel`=1. Branches when TOS is zero, otherwise IP+1. TOS_is_zero goes straight from the datapath to the next-address unit.
  - 11/01 RET: `ip_reg_sel`=1, `ip_tos_sel`=0, plus `rpop`.
  - 11/10 EXEC: `ip_reg_sel`=1, `ip_tos_sel`=1.
  - 11/11 reserved: decoded as ALU.
- FSM has two states, FETCH and ISSUE.
  - FETCH: `imem_req`=1, `imem_addr`=IP. On `imem_ack`, latch `imem_data` into the instruction register and go to ISSUE.
  - ISSUE: `insn_valid`=1, selects decoded from the instruction register. On `insn_ready`, set IP to `ip_result`, pulse `rpush`/`rpop` as decoded (this cycle only), and go to FETCH.
- Selects, `rpush` and `rpop` are 0 outside ISSUE. `rpush`/`rpop` are asserted only in the `insn_ready` cycle.
- IP arithmetic wraps modulo 2^iaddr_width; this is the next-address unit's behaviour and is not checked here.

## Timing
- Reset values: state FETCH, IP=`reset_vector`, instruction register 0. `imem_req` is 1 from the first cycle after reset release; `insn_valid`, `rpush`, `rpop` and all selects are 0.
- During reset `imem_req` is 0. An `imem_ack` during reset, or one arriving in FETCH for a request that reset aborted, is ignored. The memory side must drop any outstanding fetch on reset.
- `imem_req` and `imem_addr` stay stable from assertion until `imem_ack`. `imem_ack` is legal in the same cycle `imem_req` rises (zero-wait memory).
- `insn` and all selects stay stable while `insn_valid`=1 and `insn_ready`=0.
- Throughput: 2 cycles per instruction minimum (ack in cycle 1 of FETCH, ready in cycle 1 of ISSUE). Each wait state on either side adds one cycle.
- `ip_result` is sampled only in the `insn_ready` cycle; TOS must be valid then.
- There is no prefetch; the next fetch address is the committed IP only.

## Structure
- A shared package holds:
  - class/sub-field encodings (CLS_ALU, CLS_JMP, CLS_CALL, CLS_MISC; SUB_BZ, SUB_RET, SUB_EXEC);
  - field position constants;
  - the FSM state encoding.
- One natural sub-module: `ip_decode`, purely combinational, mapping instruction word to the select and `rpush`/`rpop` set. It is reused by the disassembler/trace monitor.
- The next-address unit is instantiated at CPU level, not inside this block.

## Test plan
Each bench instantiates the sequencer, the next-address unit, a memory model with programmable ack latency, and a return-stack model.
- **Reset:** hold `rst_n`=0 for 3 cycles with `reset_vector`=0x010 → after release `imem_req`=1, `imem_addr`=0x010, `insn_valid`=0; an ack injected during reset has no effect.
- **ALU then JMP:** ALU at 0x010, JMP 0x200 at 0x011, zero-wait memory, `insn_ready` tied high → fetch addresses 0x010, 0x011, 0x200; 2 cycles per instruction.
- **CALL/RET:** CALL 0x300 at 0x020 → `rpush`=1 for one cycle with `rpush_data`=0x021, next fetch 0x300; RET there with return-stack top 0x021 → `rpop`=1, next fetch 0x021.
- **BZ 0x080 at 0x040:** TOS=0 → next fetch 0x080; TOS=5 → next fetch 0x041.
- **Wait states:** ack latency 3 and `insn_ready` delayed 2 cycles → `imem_addr` and `insn` stable throughout; IP commits exactly once; 7 cycles for that instruction.
- **Reset mid-operation:** `rst_n` low during FETCH wait, and separately during ISSUE of a CALL → no `rpush`, IP=`reset_vector`, state FETCH.
